// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use interlock and multi-cycle divide stall
//
// Purpose:
//   Generates per-stage hold signals for a 6-stage in-order pipeline.
//   A load-use dependency between EX and ID holds PC/IF/ID for one cycle and
//   injects a bubble into EX. A divide in EX holds PC/IF/ID/EX for DIV_CYCLES
//   cycles, then pulses div_ready as the result leaves EX. Divides take
//   priority over load-use.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous active-high reset
//   id_re1/2       in   1   ID operand 1/2 is read
//   id_raddr1/2    in   5   ID source register numbers
//   ex_load        in   1   EX instruction is a load
//   ex_rf_we       in   1   EX instruction writes the register file
//   ex_rf_waddr    in   5   EX destination register
//   ex_div         in   1   EX instruction is div/divu
//   stall          out  6   hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//   ex_bubble      out  1   insert a NOP into EX on the next edge
//   div_busy       out  1   divider occupies EX
//   div_ready      out  1   one-cycle pulse, divider result valid
//   load_stall_cnt out 32   count of load-use bubble cycles (saturating)
//   div_stall_cnt  out 32   count of EX-hold cycles (saturating)
//
// Configuration:
//   HAZARD_STAT_EN  when defined, the statistics counters are implemented;
//                   otherwise both counters are tied to zero.

module hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
  input  logic        ex_load,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_div,
  output logic [5:0]  stall,
  output logic        ex_bubble,
  output logic        div_busy,
  output logic        div_ready,
  output logic [31:0] load_stall_cnt,
  output logic [31:0] div_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [5:0] STALL_LOAD = 6'b000111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;
  // The IDLE entry cycle already stalls once, so BUSY lasts DIV_CYCLES-1 cycles.
  localparam logic [5:0] CNT_LOAD   = 6'(DIV_CYCLES - 2);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_hit;

  // $0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_hit = ex_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                    ((id_re1 && (id_raddr1 == ex_rf_waddr)) ||
                     (id_re2 && (id_raddr2 == ex_rf_waddr)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 6'b000000;
    ex_bubble = 1'b0;
    div_busy  = 1'b0;
    div_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_div) begin
          stall   = STALL_DIV;
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end else if (load_hit) begin
          stall     = STALL_LOAD;
          ex_bubble = 1'b1;
        end
      end
      BUSY: begin
        stall    = STALL_DIV;
        div_busy = 1'b1;
        if (cnt_q == 6'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: begin
        // ex_div still reflects the divide that is leaving EX this cycle.
        div_ready = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      stall     = 6'b000000;
      ex_bubble = 1'b0;
      div_busy  = 1'b0;
      div_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] load_stall_cnt_q;
  logic [31:0] div_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_stall_cnt_q <= 32'd0;
      div_stall_cnt_q  <= 32'd0;
    end else begin
      if (ex_bubble && (load_stall_cnt_q != 32'hFFFF_FFFF)) begin
        load_stall_cnt_q <= load_stall_cnt_q + 32'd1;
      end
      if (stall[3] && (div_stall_cnt_q != 32'hFFFF_FFFF)) begin
        div_stall_cnt_q <= div_stall_cnt_q + 32'd1;
      end
    end
  end

  assign load_stall_cnt = load_stall_cnt_q;
  assign div_stall_cnt  = div_stall_cnt_q;
`else
  assign load_stall_cnt = 32'd0;
  assign div_stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_re1, id_re2;
  logic [4:0]  id_raddr1, id_raddr2;
  logic        ex_load, ex_rf_we, ex_div;
  logic [4:0]  ex_rf_waddr;
  logic [5:0]  stall;
  logic        ex_bubble, div_busy, div_ready;
  logic [31:0] load_stall_cnt, div_stall_cnt;

  hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_re1         (id_re1),
    .id_re2         (id_re2),
    .id_raddr1      (id_raddr1),
    .id_raddr2      (id_raddr2),
    .ex_load        (ex_load),
    .ex_rf_we       (ex_rf_we),
    .ex_rf_waddr    (ex_rf_waddr),
    .ex_div         (ex_div),
    .stall          (stall),
    .ex_bubble      (ex_bubble),
    .div_busy       (div_busy),
    .div_ready      (div_ready),
    .load_stall_cnt (load_stall_cnt),
    .div_stall_cnt  (div_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        bubble;
    logic        busy;
    logic        ready;
    logic [31:0] ld_cnt;
    logic [31:0] dv_cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Expected statistics as seen during the cycle being pushed (before its edge).
  logic [31:0] m_ld = 32'd0;
  logic [31:0] m_dv = 32'd0;

  // Monitor: one output sample per cycle, taken on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if ({stall, ex_bubble, div_busy, div_ready} != {e.stall, e.bubble, e.busy, e.ready} ||
          load_stall_cnt != e.ld_cnt || div_stall_cnt != e.dv_cnt) begin
        n_fail++;
        $display("FAIL %s: got stall=%b bub=%b busy=%b rdy=%b ldc=%0d dvc=%0d, exp stall=%b bub=%b busy=%b rdy=%b ldc=%0d dvc=%0d",
                 e.name, stall, ex_bubble, div_busy, div_ready, load_stall_cnt, div_stall_cnt,
                 e.stall, e.bubble, e.busy, e.ready, e.ld_cnt, e.dv_cnt);
      end
    end
  end

  task automatic vec(input string nm, input logic r, input logic dv,
                     input logic ld, input logic we, input logic [4:0] wa,
                     input logic r1, input logic [4:0] a1,
                     input logic r2, input logic [4:0] a2,
                     input logic [5:0] es, input logic eb, input logic ebusy, input logic erdy);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_div = dv; ex_load = ld; ex_rf_we = we; ex_rf_waddr = wa;
    id_re1 = r1; id_raddr1 = a1; id_re2 = r2; id_raddr2 = a2;
    e.name = nm; e.stall = es; e.bubble = eb; e.busy = ebusy; e.ready = erdy;
`ifdef HAZARD_STAT_EN
    e.ld_cnt = m_ld; e.dv_cnt = m_dv;
`else
    e.ld_cnt = 32'd0; e.dv_cnt = 32'd0;
`endif
    sb.push_back(e);
    if (r) begin
      m_ld = 32'd0; m_dv = 32'd0;
    end else begin
      if (eb) m_ld = m_ld + 32'd1;
      if (es[3]) m_dv = m_dv + 32'd1;
    end
  endtask

  task automatic idle(input string nm);
    vec(nm, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b000000, 0, 0, 0);
  endtask

  // Full divide with ex_div held while the divide sits in EX (including DONE).
  task automatic divide(input string nm);
    vec({nm, "_entry"}, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b001111, 0, 0, 0);
    for (int i = 0; i < 31; i++)
      vec({nm, "_busy"}, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b001111, 0, 1, 0);
    vec({nm, "_done"}, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b000000, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; ex_div = 0; ex_load = 0; ex_rf_we = 0; ex_rf_waddr = 0;
    id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
    repeat (2) @(posedge clk);

    // Reset forces outputs low even with hazards present.
    vec("rst_div_hit", 1, 1, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 6'b000000, 0, 0, 0);
    vec("rst_hold",    1, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 6'b000000, 0, 0, 0);
    idle("idle0");

    // Load-use hits and non-hits.
    vec("lu_r5_re1",   0, 0, 1, 1, 5'd5,  1, 5'd5,  0, 5'd0,  6'b000111, 1, 0, 0);
    idle("lu_after");
    vec("lu_r0",       0, 0, 1, 1, 5'd0,  1, 5'd0,  0, 5'd0,  6'b000000, 0, 0, 0);
    vec("lu_re1_off",  0, 0, 1, 1, 5'd5,  0, 5'd5,  0, 5'd0,  6'b000000, 0, 0, 0);
    vec("lu_r7_re2",   0, 0, 1, 1, 5'd7,  0, 5'd0,  1, 5'd7,  6'b000111, 1, 0, 0);
    vec("lu_no_we",    0, 0, 1, 0, 5'd7,  0, 5'd0,  1, 5'd7,  6'b000000, 0, 0, 0);
    vec("lu_no_load",  0, 0, 0, 1, 5'd7,  1, 5'd7,  1, 5'd7,  6'b000000, 0, 0, 0);
    vec("lu_addr_ne",  0, 0, 1, 1, 5'd8,  1, 5'd9,  1, 5'd10, 6'b000000, 0, 0, 0);
    vec("lu_r31_re1",  0, 0, 1, 1, 5'd31, 1, 5'd31, 0, 5'd0,  6'b000111, 1, 0, 0);
    idle("idle1");

    // Divide entry coinciding with a load-use hit: divide wins.
    vec("div_vs_lu",   0, 1, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 6'b001111, 0, 0, 0);
    for (int i = 0; i < 31; i++)
      vec("div1_busy", 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b001111, 0, 1, 0);
    vec("div1_done",   0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b000000, 0, 0, 1);

    // Back-to-back divide enters the cycle after DONE.
    divide("div2");
    idle("idle2");

    // Reset at cycle 10 of a divide aborts without div_ready.
    vec("div3_entry",  0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b001111, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      vec("div3_busy", 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b001111, 0, 1, 0);
    vec("div3_rst",    1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b000000, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle("post_abort");
    vec("lu_post",     0, 0, 1, 1, 5'd3, 0, 5'd0, 1, 5'd3, 6'b000111, 1, 0, 0);
    idle("idle3");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, exp 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of cycles the EX-stage divider occupies; legal range 2..63.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_re1 / id_re2  in  1 each  ID-stage source operand 1 / 2 is read.
REQ-005 SHALL have ports id_raddr1 / id_raddr2  in  5 each  ID-stage source register numbers.
REQ-006 SHALL have port ex_load  in  1  instruction in EX is a load.
REQ-007 SHALL have ports ex_rf_we  in  1 and ex_rf_waddr  in  5  EX-stage register write enable and destination.
REQ-008 SHALL have port ex_div  in  1  instruction in EX is div/divu.
REQ-009 SHALL have port stall  out  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-010 SHALL have port ex_bubble  out  1  insert a NOP into EX on the next edge.
REQ-011 SHALL have port div_busy  out  1  high while the divider occupies EX.
REQ-012 SHALL have port div_ready  out  1  one-cycle pulse: divider result valid, EX may advance.
REQ-013 SHALL have ports load_stall_cnt / div_stall_cnt  out  32 each  statistics counters (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE with a 6-bit down-counter cnt.
REQ-015 Load-use hit SHALL be defined as: ex_load & ex_rf_we & ex_rf_waddr != 0 & ((id_re1 & id_raddr1 == ex_rf_waddr) | (id_re2 & id_raddr2 == ex_rf_waddr)).
REQ-016 In IDLE with ex_div=0 and a load-use hit, stall SHALL be 6'b000111 and ex_bubble SHALL be 1, combinationally in the same cycle; exactly one stall cycle per hit.
REQ-017 Register $0 SHALL never cause a load-use stall.
REQ-018 In IDLE with ex_div=1: stall SHALL be 6'b001111 that cycle, ex_bubble SHALL be 0, the next state SHALL be BUSY, and cnt SHALL be loaded with DIV_CYCLES-2.
REQ-019 In BUSY: stall SHALL be 6'b001111 and div_busy SHALL be 1; if cnt==0 the next state SHALL be DONE, else cnt SHALL decrement.
REQ-020 Total stall cycles per divide SHALL equal DIV_CYCLES, counting the IDLE entry cycle.
REQ-021 In DONE: stall SHALL be 0 and div_ready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally; ex_div is ignored in DONE because the same divide is leaving EX.
REQ-022 Divide handling SHALL take priority over load-use; load-use is evaluated only in IDLE with ex_div=0.
REQ-023 Back-to-back divides SHALL be handled as follows: the second divide enters EX the cycle after DONE, and IDLE then restarts the sequence normally.
REQ-024 stall bits 4 and 5 SHALL always be 0.

Reset
REQ-025 While rst=1, stall, ex_bubble, div_busy and div_ready SHALL be forced to 0 combinationally.
REQ-026 On a clock edge with rst=1, state SHALL become IDLE, cnt 0, and both statistics counters 0.
REQ-027 Reset asserted mid-divide (BUSY or DONE) SHALL abort the divide with no div_ready pulse.

Configuration
REQ-028 With macro HAZARD_STAT_EN defined, load_stall_cnt SHALL increment on every edge where ex_bubble=1, and div_stall_cnt SHALL increment on every edge where stall[3]=1.
REQ-029 With HAZARD_STAT_EN defined, both counters SHALL saturate at 32'hFFFFFFFF.
REQ-030 Without HAZARD_STAT_EN, both counters SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-031 SHALL cover: ex_load=1, ex_rf_we=1, ex_rf_waddr=5, id_re1=1, id_raddr1=5 -> stall=000111 and ex_bubble=1 for 1 cycle, then 0.
REQ-032 SHALL cover: same as REQ-031 but waddr=raddr1=0, or id_re1=0 -> stall=0, ex_bubble=0.
REQ-033 SHALL cover: ex_div pulse in IDLE with DIV_CYCLES=32 -> stall=001111 for 32 consecutive cycles, div_busy for 31, div_ready high on cycle 33, stall=0 that cycle.
REQ-034 SHALL cover: ex_div=1 and load-use hit in the same cycle -> stall=001111, ex_bubble=0 (divide wins).
REQ-035 SHALL cover: rst=1 at cycle 10 of a divide -> outputs 0 immediately; after release, IDLE with no div_ready pulse.
REQ-036 SHALL cover: with HAZARD_STAT_EN, 3 load-use hits plus one 32-cycle divide -> load_stall_cnt=3, div_stall_cnt=32; without the macro both counters read 0.
